decode_msg_ctrl: RTL and testbench

Sequencer that streams a decoded Kyber message polynomial out as a sequence of memory write beats. It accepts a 256-bit message over a valid/ready handshake and latches it. It then emits LANES decoded coefficients per beat, with an address, into the polynomial RAM / NTT input buffer. Each coefficient is 0 for a 0 bit and (Q+1)/2 = 1665 for a 1 bit, the same mapping as the combinational message decoder, but time-multiplexed so that the full N*COEFF_W bus never needs routing.

---
 rtl/decode_msg_ctrl.sv | 118 +++++++++++
 tb/tb_decode_msg_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_msg_ctrl.sv
// decode_msg_ctrl
//   Accepts one N-bit Kyber message over a valid/ready handshake. It then
//   streams the decoded polynomial as N/LANES write beats, with LANES
//   coefficients per beat. Each coefficient is 0 for a 0 bit and (Q+1)/2
//   for a 1 bit.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   msg_valid/msg_ready/msg      message input handshake (bit i -> coeff i)
//   flush                        synchronous abort back to IDLE
//   out_valid/out_ready          beat handshake
//   out_addr                     beat index k
//   out_data                     lane j = coeff k*LANES+j
//   out_last                     final beat marker
//   busy                         high while streaming
//   done                         one-cycle pulse after the final beat is taken
module decode_msg_ctrl #(
  parameter  int N       = 256,
  parameter  int COEFF_W = 12,
  parameter  int Q       = 3329,
  parameter  int LANES   = 4,
  localparam int AW      = $clog2(N / LANES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     msg_valid,
  output logic                     msg_ready,
  input  logic [N-1:0]             msg,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AW-1:0]            out_addr,
  output logic [LANES*COEFF_W-1:0] out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int                 BEATS  = N / LANES;
  localparam logic [AW-1:0]      LAST_K = AW'(BEATS - 1);
  localparam logic [COEFF_W-1:0] ONE    = COEFF_W'((Q + 1) / 2);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state;
  logic [N-1:0]    msg_r;
  logic [AW-1:0]   k_next;

  function automatic logic [LANES*COEFF_W-1:0] decode(input logic [LANES-1:0] bits);
    logic [LANES*COEFF_W-1:0] d;
    d = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      d[j*COEFF_W +: COEFF_W] = bits[j] ? ONE : '0;
    end
    return d;
  endfunction

  // Combinational so that flush (and reset) suppress acceptance in the same cycle.
  assign msg_ready = rst_n && !flush && (state == IDLE);
  assign k_next    = out_addr + AW'(1);

  // out_addr doubles as the beat counter k. The next beat's data is decoded
  // one cycle ahead, so the beat registers stay stable under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      msg_r     <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_addr  <= '0;
        out_data  <= '0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (msg_valid) begin
              msg_r     <= msg;
              out_addr  <= '0;
              out_data  <= decode(msg[LANES-1:0]);
              out_last  <= (BEATS == 1);
              out_valid <= 1'b1;
              busy      <= 1'b1;
              state     <= STREAM;
            end
          end
          STREAM: begin
            if (out_ready) begin
              if (out_last) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
                out_addr  <= '0;
                out_data  <= '0;
                out_last  <= 1'b0;
              end else begin
                out_addr <= k_next;
                out_data <= decode(msg_r[int'(k_next)*LANES +: LANES]);
                out_last <= (k_next == LAST_K);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decode_msg_ctrl.sv
// tb_decode_msg_ctrl
//   Directed sequence of message streams with a reference model that derives
//   each beat directly from the message bits.
module tb_decode_msg_ctrl;

  localparam int N       = 256;
  localparam int COEFF_W = 12;
  localparam int LANES   = 4;
  localparam int AW      = 6;
  localparam int BEATS   = N / LANES;
  localparam int ONE     = 1665;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     msg_valid;
  logic                     msg_ready;
  logic [N-1:0]             msg;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [AW-1:0]            out_addr;
  logic [LANES*COEFF_W-1:0] out_data;
  logic                     out_last;
  logic                     busy;
  logic                     done;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  decode_msg_ctrl #(.N(N), .COEFF_W(COEFF_W), .Q(3329), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg(msg), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference beat: lane j holds 1665 when message bit k*LANES+j is set.
  function automatic logic [63:0] model_beat(input logic [N-1:0] m, input int k);
    logic [63:0] d;
    d = '0;
    for (int j = 0; j < LANES; j++) begin
      if (m[k*LANES + j]) d = d + (64'(ONE) << (j * COEFF_W));
    end
    return d;
  endfunction

  function automatic logic [N-1:0] rand_msg();
    logic [N-1:0] m;
    for (int i = 0; i < N / 32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  // Called at a negedge where msg_ready is expected; returns at the negedge
  // after acceptance, when beat 0 should be visible.
  task automatic send_msg(input logic [N-1:0] m);
    msg       = m;
    msg_valid = 1'b1;
    #1;
    chk("send_ready", msg_ready, 1);
    @(negedge clk);
    msg_valid = 1'b0;
  endtask

  // Consumes beats 0..stop-1 and checks each against the model. When stop is
  // BEATS, it also checks the done cycle. It returns the cycle count since
  // acceptance.
  task automatic stream(input logic [N-1:0] m, input bit bp, input int stop,
                        output int cycles);
    int  k     = 0;
    int  guard = 0;
    bit  rdy;
    cycles = 1;
    while (k < stop && guard < 2000) begin
      chk("beat_valid", out_valid, 1);
      chk("beat_addr", out_addr, k);
      chk("beat_data", out_data, model_beat(m, k));
      chk("beat_last", out_last, (k == BEATS - 1));
      chk("beat_busy", busy, 1);
      chk("beat_mready", msg_ready, 0);
      rdy       = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
      out_ready = rdy;
      @(negedge clk);
      cycles++;
      guard++;
      if (rdy) k++;
    end
    out_ready = 1'b0;
    if (guard >= 2000) chk("stream_timeout", guard, 0);
    if (stop == BEATS) begin
      chk("done_pulse", done, 1);
      chk("done_valid", out_valid, 0);
      chk("done_busy", busy, 0);
      chk("done_mready", msg_ready, 1);
    end
  endtask

  logic [N-1:0] m1, m2;
  int           cyc;

  initial begin
    rst_n     = 1'b0;
    msg_valid = 1'b0;
    msg       = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset for two cycles, then idle.
    @(negedge clk);
    @(negedge clk);
    chk("rst_mready", msg_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_data", out_data, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_mready", msg_ready, 1);
    @(negedge clk);
    chk("idle_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // All ones, no backpressure: done 65 cycles after acceptance.
    m1 = '1;
    send_msg(m1);
    stream(m1, 1'b0, BEATS, cyc);
    chk("latency", cyc, 65);
    @(negedge clk);
    chk("done_once", done, 0);

    // Directed 16'h3FA1 pattern.
    m1 = '0;
    m1[15:0] = 16'h3FA1;
    send_msg(m1);
    stream(m1, 1'b0, BEATS, cyc);
    @(negedge clk);

    // Random message with random backpressure.
    for (int t = 0; t < 2; t++) begin
      m1 = rand_msg();
      send_msg(m1);
      stream(m1, 1'b1, BEATS, cyc);
      @(negedge clk);
    end

    // Flush at beat 10 with msg_valid held high.
    m1 = rand_msg();
    send_msg(m1);
    stream(m1, 1'b0, 10, cyc);
    chk("pre_flush_addr", out_addr, 10);
    m2        = rand_msg();
    msg       = m2;
    msg_valid = 1'b1;
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("flush_mready_stream", msg_ready, 0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_done", done, 0);
    chk("flush_busy", busy, 0);
    chk("flush_mready", msg_ready, 0);
    @(negedge clk);
    chk("flush_idle_valid", out_valid, 0);
    chk("flush_idle_done", done, 0);
    flush = 1'b0;
    #1;
    chk("unflush_mready", msg_ready, 1);
    @(negedge clk);
    msg_valid = 1'b0;
    stream(m2, 1'b0, BEATS, cyc);
    @(negedge clk);

    // Flush together with the final handshake: no done pulse.
    m1 = rand_msg();
    send_msg(m1);
    stream(m1, 1'b0, BEATS - 1, cyc);
    chk("final_last", out_last, 1);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("flush_last_done", done, 0);
    chk("flush_last_valid", out_valid, 0);
    @(negedge clk);

    // Reset at beat 30.
    m1 = rand_msg();
    send_msg(m1);
    stream(m1, 1'b0, 30, cyc);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_mready", msg_ready, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_addr", out_addr, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back to back: the second message is offered during the first stream
    // and is accepted in the done cycle.
    m1 = rand_msg();
    m2 = rand_msg();
    send_msg(m1);
    msg       = m2;
    msg_valid = 1'b1;
    stream(m1, 1'b1, BEATS, cyc);
    @(negedge clk);
    msg_valid = 1'b0;
    stream(m2, 1'b0, BEATS, cyc);
    chk("b2b_latency", cyc, 65);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
